// File: rtl/conv_seq_pkg.sv
// Shared types and sizing helpers for the conv layer frame sequencer.
package conv_seq_pkg;

    localparam int unsigned PIX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    // Address width for a frame of n_pix pixels (at least one bit).
    function automatic int unsigned addr_w(input int unsigned n_pix);
        return (n_pix < 2) ? 1 : $clog2(n_pix);
    endfunction

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int unsigned cnt_bits(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/conv_frame_sequencer.sv
// Streams one input feature map from SRAM into a 3x3 conv layer, appends flush
// pixels, counts the layer's outputs and reports frame completion or timeout.
module conv_frame_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned IMG_H      = 28,
    parameter int unsigned CH_IN      = 16,
    parameter int unsigned FLUSH_PIX  = IMG_W,
    parameter int unsigned OUT_EXPECT = IMG_W * IMG_H,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned ADDR_W     = addr_w(IMG_W * IMG_H)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic [PIX_W*CH_IN-1:0]   mem_rd_data,
    output logic                     conv_in_valid,
    output logic [PIX_W*CH_IN-1:0]   conv_in_data,
    input  logic                     conv_out_valid,
    output logic [ADDR_W:0]          frame_out_cnt
);

    localparam int unsigned DATA_W = PIX_W * CH_IN;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned FL_W   = cnt_bits(FLUSH_PIX);
    localparam int unsigned TO_W   = cnt_bits(TIMEOUT);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'((FLUSH_PIX == 0) ? 0 : FLUSH_PIX - 1);
    localparam logic [CNT_W-1:0]  OUT_MAX    = CNT_W'(OUT_EXPECT);
    localparam logic [TO_W-1:0]   TO_MAX     = TO_W'(TIMEOUT);

    seq_state_e         state_q, state_d;
    logic               mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]  mem_rd_addr_q, mem_rd_addr_d;
    logic               flush_en_q, flush_en_d;
    logic [FL_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [TO_W-1:0]    timer_q, timer_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_zero_q, s1_zero_d;
    logic               conv_in_valid_q, conv_in_valid_d;
    logic [DATA_W-1:0]  conv_in_data_q, conv_in_data_d;
    logic [CNT_W-1:0]   frame_out_cnt_q, frame_out_cnt_d;
    logic               done_q, done_d;
    logic               err_timeout_q, err_timeout_d;

    assign busy = (state_q == ST_FEED) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN);

    // Next-state, issue and pipe logic.
    always_comb begin
        state_d         = state_q;
        mem_rd_en_d     = 1'b0;
        mem_rd_addr_d   = mem_rd_addr_q;
        flush_en_d      = 1'b0;
        flush_cnt_d     = flush_cnt_q;
        timer_d         = timer_q;
        done_d          = 1'b0;
        err_timeout_d   = err_timeout_q;
        frame_out_cnt_d = frame_out_cnt_q;

        if (busy && conv_out_valid && (frame_out_cnt_q != OUT_MAX)) begin
            frame_out_cnt_d = frame_out_cnt_q + 1'b1;
        end

        // A pixel read now is on mem_rd_data next cycle, so stage 1 follows the issue strobes.
        s1_valid_d      = mem_rd_en_q | flush_en_q;
        s1_zero_d       = flush_en_q;
        conv_in_valid_d = s1_valid_q;
        conv_in_data_d  = (s1_valid_q && !s1_zero_q) ? mem_rd_data : '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d         = ST_FEED;
                    mem_rd_en_d     = 1'b1;
                    mem_rd_addr_d   = '0;
                    flush_cnt_d     = '0;
                    timer_d         = '0;
                    err_timeout_d   = 1'b0;
                    frame_out_cnt_d = '0;
                end
            end
            ST_FEED: begin
                if (mem_rd_addr_q == LAST_ADDR) begin
                    if (FLUSH_PIX == 0) begin
                        state_d = ST_DRAIN;
                        timer_d = '0;
                    end else begin
                        state_d     = ST_FLUSH;
                        flush_en_d  = 1'b1;
                        flush_cnt_d = '0;
                    end
                end else begin
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = mem_rd_addr_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_DRAIN;
                    timer_d = '0;
                end else begin
                    flush_en_d  = 1'b1;
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Completion looks at the updated count so done follows the last output by one cycle.
                if (frame_out_cnt_d == OUT_MAX) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (timer_q == TO_MAX) begin
                    state_d       = ST_DONE;
                    done_d        = 1'b1;
                    err_timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d         = ST_IDLE;
            mem_rd_en_d     = 1'b0;
            flush_en_d      = 1'b0;
            s1_valid_d      = 1'b0;
            s1_zero_d       = 1'b0;
            conv_in_valid_d = 1'b0;
            conv_in_data_d  = '0;
            done_d          = 1'b0;
            err_timeout_d   = err_timeout_q;
            frame_out_cnt_d = frame_out_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            mem_rd_en_q     <= 1'b0;
            mem_rd_addr_q   <= '0;
            flush_en_q      <= 1'b0;
            flush_cnt_q     <= '0;
            timer_q         <= '0;
            s1_valid_q      <= 1'b0;
            s1_zero_q       <= 1'b0;
            conv_in_valid_q <= 1'b0;
            conv_in_data_q  <= '0;
            frame_out_cnt_q <= '0;
            done_q          <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_rd_en_q     <= mem_rd_en_d;
            mem_rd_addr_q   <= mem_rd_addr_d;
            flush_en_q      <= flush_en_d;
            flush_cnt_q     <= flush_cnt_d;
            timer_q         <= timer_d;
            s1_valid_q      <= s1_valid_d;
            s1_zero_q       <= s1_zero_d;
            conv_in_valid_q <= conv_in_valid_d;
            conv_in_data_q  <= conv_in_data_d;
            frame_out_cnt_q <= frame_out_cnt_d;
            done_q          <= done_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    assign mem_rd_en     = mem_rd_en_q;
    assign mem_rd_addr   = mem_rd_addr_q;
    assign conv_in_valid = conv_in_valid_q;
    assign conv_in_data  = conv_in_data_q;
    assign frame_out_cnt = frame_out_cnt_q;
    assign done          = done_q;
    assign err_timeout   = err_timeout_q;

endmodule
